// File: rtl/note_tone_synth_if.sv
// Command/audio bundle between the note lookup stage, the tone synth and the audio output path.
// The master side issues note commands and sample ticks and receives the audio stream.
interface note_tone_synth_if #(
    parameter int SAMPLE_W = 8
);
    logic                note_valid_in;
    logic [5:0]          note_index_in;
    logic                sample_tick_in;
    logic [SAMPLE_W-1:0] audio_out;
    logic                audio_valid_out;
    logic                busy_out;
    logic [4:0]          playing_note_out;
    logic                reject_out;

    modport master (
        output note_valid_in,
        output note_index_in,
        output sample_tick_in,
        input  audio_out,
        input  audio_valid_out,
        input  busy_out,
        input  playing_note_out,
        input  reject_out
    );

    modport slave (
        input  note_valid_in,
        input  note_index_in,
        input  sample_tick_in,
        output audio_out,
        output audio_valid_out,
        output busy_out,
        output playing_note_out,
        output reject_out
    );
endinterface

// File: rtl/note_tone_synth.sv
// Plays a transcribed note index back as a sawtooth tone: bin table -> phase increment ->
// phase accumulator stepped on each audio sample tick, for a fixed number of samples per note.
module note_tone_synth #(
    parameter int NUM_NOTES      = 22,
    parameter int PHASE_W        = 24,
    parameter int SAMPLE_W       = 8,
    parameter int INC_PER_BIN    = 4096,
    parameter int DURATION_TICKS = 4800
) (
    input  logic            clk_in,
    input  logic            rst_in,
    note_tone_synth_if.slave bus
);
    localparam int TABLE_SIZE = 22;
    localparam int CNT_W      = $clog2(DURATION_TICKS + 1);

    localparam int BIN_TABLE [TABLE_SIZE] = '{
        126, 133, 141, 149, 158, 168, 178, 188, 200, 212, 224,
        238, 252, 267, 283, 299, 317, 336, 356, 377, 400, 424
    };

    localparam logic [SAMPLE_W-1:0] MIDSCALE      = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]    LAST_TICK     = CNT_W'(DURATION_TICKS - 1);
    localparam logic [5:0]          NUM_NOTES_CMP = 6'(NUM_NOTES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [PHASE_W-1:0]  phase_reg;
    logic [PHASE_W-1:0]  inc_reg;
    logic [CNT_W-1:0]    tick_count_reg;
    logic [SAMPLE_W-1:0] audio_reg;
    logic                audio_valid_reg;
    logic                reject_reg;
    logic [4:0]          playing_note_reg;

    logic load_en;
    logic play_en;
    logic busy;

    // Phase increments are fixed at elaboration; entries beyond the bin table play nothing.
    logic [PHASE_W-1:0] inc_table [NUM_NOTES];

    generate
        for (genvar gi = 0; gi < NUM_NOTES; gi++) begin : g_inc_table
            if (gi < TABLE_SIZE) begin : g_entry
                localparam logic [31:0] INC_FULL = 32'(BIN_TABLE[gi] * INC_PER_BIN);
                assign inc_table[gi] = INC_FULL[PHASE_W-1:0];
            end else begin : g_empty
                assign inc_table[gi] = '0;
            end
        end
    endgenerate

    // Command decode
    logic       cmd_present;
    logic [4:0] cmd_note;
    logic       cmd_in_range;
    logic       cmd_accept;
    logic       cmd_reject;
    logic       cmd_silence;

    assign cmd_present  = bus.note_index_in[5];
    assign cmd_note     = bus.note_index_in[4:0];
    assign cmd_in_range = ({1'b0, cmd_note} < NUM_NOTES_CMP);
    assign cmd_accept   = bus.note_valid_in &  cmd_present &  cmd_in_range;
    assign cmd_reject   = bus.note_valid_in &  cmd_present & ~cmd_in_range;
    assign cmd_silence  = bus.note_valid_in & ~cmd_present;

    logic [PHASE_W-1:0]  phase_sum;
    logic [SAMPLE_W-1:0] tone_sample;
    logic                last_sample;

    assign phase_sum   = phase_reg + inc_reg;
    assign tone_sample = phase_sum[PHASE_W-1 -: SAMPLE_W];
    assign last_sample = (tick_count_reg == LAST_TICK);

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; a note command overrides whatever the tick would have done.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: state_next = ST_IDLE;
            ST_LOAD: state_next = ST_PLAY;
            ST_PLAY: begin
                if (bus.sample_tick_in && last_sample) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (cmd_accept) begin
            state_next = ST_LOAD;
        end else if (cmd_silence) begin
            state_next = ST_IDLE;
        end
    end

    // Output decode from the registered state
    always_comb begin
        load_en = 1'b0;
        play_en = 1'b0;
        busy    = 1'b0;
        case (state_reg)
            ST_LOAD: begin
                load_en = 1'b1;
                busy    = 1'b1;
            end
            ST_PLAY: begin
                play_en = 1'b1;
                busy    = 1'b1;
            end
            default: begin
                load_en = 1'b0;
                play_en = 1'b0;
                busy    = 1'b0;
            end
        endcase
    end

    // Datapath: the tick is handled against the current state first, then commands take over.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            phase_reg        <= '0;
            inc_reg          <= '0;
            tick_count_reg   <= '0;
            audio_reg        <= MIDSCALE;
            audio_valid_reg  <= 1'b0;
            reject_reg       <= 1'b0;
            playing_note_reg <= '0;
        end else begin
            audio_valid_reg <= bus.sample_tick_in;
            reject_reg      <= cmd_reject;

            if (bus.sample_tick_in) begin
                if (play_en) begin
                    phase_reg      <= phase_sum;
                    audio_reg      <= tone_sample;
                    tick_count_reg <= tick_count_reg + 1'b1;
                end else begin
                    audio_reg <= MIDSCALE;
                end
            end

            if (load_en) begin
                inc_reg        <= inc_table[playing_note_reg];
                phase_reg      <= '0;
                tick_count_reg <= '0;
            end

            if (cmd_accept) begin
                playing_note_reg <= cmd_note;
                phase_reg        <= '0;
            end else if (cmd_silence) begin
                phase_reg <= '0;
            end
        end
    end

    assign bus.audio_out        = audio_reg;
    assign bus.audio_valid_out  = audio_valid_reg;
    assign bus.busy_out         = busy;
    assign bus.playing_note_out = playing_note_reg;
    assign bus.reject_out       = reject_reg;

endmodule

// File: tb/tb_note_tone_synth.sv
// Directed bench for note_tone_synth: short-duration instance for most scenarios plus a
// longer-duration instance sharing the same stimulus to observe phase wrap-around.
module tb_note_tone_synth;
    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;

    note_tone_synth_if #(.SAMPLE_W(8)) bus_a ();
    note_tone_synth_if #(.SAMPLE_W(8)) bus_b ();

    assign bus_b.note_valid_in  = bus_a.note_valid_in;
    assign bus_b.note_index_in  = bus_a.note_index_in;
    assign bus_b.sample_tick_in = bus_a.sample_tick_in;

    note_tone_synth #(
        .NUM_NOTES(22), .PHASE_W(24), .SAMPLE_W(8),
        .INC_PER_BIN(4096), .DURATION_TICKS(8)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus_a)
    );

    note_tone_synth #(
        .NUM_NOTES(22), .PHASE_W(24), .SAMPLE_W(8),
        .INC_PER_BIN(4096), .DURATION_TICKS(16)
    ) dut_long (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All tasks start and end at a falling edge; outputs are read there.
    task automatic tick();
        bus_a.sample_tick_in = 1'b1;
        @(negedge clk);
        bus_a.sample_tick_in = 1'b0;
        $display("tick: audio=%02h valid=%b busy=%b note=%0d | long audio=%02h",
                 bus_a.audio_out, bus_a.audio_valid_out, bus_a.busy_out,
                 bus_a.playing_note_out, bus_b.audio_out);
    endtask

    task automatic send_note(input logic [5:0] idx);
        bus_a.note_valid_in = 1'b1;
        bus_a.note_index_in = idx;
        @(negedge clk);
        bus_a.note_valid_in = 1'b0;
        bus_a.note_index_in = 6'h00;
        $display("note cmd %02h: busy=%b note=%0d reject=%b",
                 idx, bus_a.busy_out, bus_a.playing_note_out, bus_a.reject_out);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus_a.audio_out !== 8'h80) begin failures++; $display("FAIL reset_audio: got %02h expected 80", bus_a.audio_out); end
        checks++; if (bus_a.audio_valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", bus_a.audio_valid_out); end
        checks++; if (bus_a.busy_out !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus_a.busy_out); end
        checks++; if (bus_a.reject_out !== 1'b0) begin failures++; $display("FAIL reset_reject: got %b expected 0", bus_a.reject_out); end
        checks++; if (bus_a.playing_note_out !== 5'd0) begin failures++; $display("FAIL reset_note: got %0d expected 0", bus_a.playing_note_out); end
        rst = 1'b0;
        idle_cycle();
    endtask

    task automatic test_idle_ticks();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus_a.audio_valid_out !== 1'b1) begin failures++; $display("FAIL idle_valid[%0d]: got %b expected 1", i, bus_a.audio_valid_out); end
            checks++; if (bus_a.audio_out !== 8'h80) begin failures++; $display("FAIL idle_audio[%0d]: got %02h expected 80", i, bus_a.audio_out); end
            checks++; if (bus_a.busy_out !== 1'b0) begin failures++; $display("FAIL idle_busy[%0d]: got %b expected 0", i, bus_a.busy_out); end
        end
        idle_cycle();
        checks++; if (bus_a.audio_valid_out !== 1'b0) begin failures++; $display("FAIL idle_valid_drop: got %b expected 0", bus_a.audio_valid_out); end
    endtask

    task automatic test_note0_play();
        logic [7:0] exp_s [8] = '{8'h07, 8'h0F, 8'h17, 8'h1F, 8'h27, 8'h2F, 8'h37, 8'h3F};
        send_note(6'h20);
        checks++; if (bus_a.busy_out !== 1'b1) begin failures++; $display("FAIL note0_busy_load: got %b expected 1", bus_a.busy_out); end
        checks++; if (bus_a.playing_note_out !== 5'd0) begin failures++; $display("FAIL note0_latched: got %0d expected 0", bus_a.playing_note_out); end
        tick(); // lands in LOAD
        checks++; if (bus_a.audio_out !== 8'h80) begin failures++; $display("FAIL note0_load_tick: got %02h expected 80", bus_a.audio_out); end
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++; if (bus_a.audio_out !== exp_s[k]) begin failures++; $display("FAIL note0_sample[%0d]: got %02h expected %02h", k + 1, bus_a.audio_out, exp_s[k]); end
            checks++; if (bus_a.busy_out !== (k < 7)) begin failures++; $display("FAIL note0_busy[%0d]: got %b expected %b", k + 1, bus_a.busy_out, (k < 7)); end
        end
        tick();
        checks++; if (bus_a.audio_out !== 8'h80) begin failures++; $display("FAIL note0_after_end: got %02h expected 80", bus_a.audio_out); end
    endtask

    task automatic test_note21_wrap();
        logic [7:0] exp_s [10] = '{8'h1A, 8'h35, 8'h4F, 8'h6A, 8'h84, 8'h9F, 8'hB9, 8'hD4, 8'hEE, 8'h09};
        send_note(6'h35);
        checks++; if (bus_a.playing_note_out !== 5'd21) begin failures++; $display("FAIL note21_latched: got %0d expected 21", bus_a.playing_note_out); end
        idle_cycle();
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++; if (bus_b.audio_out !== exp_s[k]) begin failures++; $display("FAIL note21_long_sample[%0d]: got %02h expected %02h", k + 1, bus_b.audio_out, exp_s[k]); end
            if (k < 8) begin
                checks++; if (bus_a.audio_out !== exp_s[k]) begin failures++; $display("FAIL note21_sample[%0d]: got %02h expected %02h", k + 1, bus_a.audio_out, exp_s[k]); end
            end else begin
                checks++; if (bus_a.audio_out !== 8'h80) begin failures++; $display("FAIL note21_after_end[%0d]: got %02h expected 80", k + 1, bus_a.audio_out); end
            end
        end
        checks++; if (bus_b.busy_out !== 1'b1) begin failures++; $display("FAIL note21_long_busy: got %b expected 1", bus_b.busy_out); end
    endtask

    task automatic test_reject();
        logic [7:0] exp_s [8] = '{8'h07, 8'h0F, 8'h17, 8'h1F, 8'h27, 8'h2F, 8'h37, 8'h3F};
        send_note(6'h20);
        idle_cycle();
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (bus_a.audio_out !== exp_s[k]) begin failures++; $display("FAIL reject_pre_sample[%0d]: got %02h expected %02h", k + 1, bus_a.audio_out, exp_s[k]); end
        end
        send_note(6'h37);
        checks++; if (bus_a.reject_out !== 1'b1) begin failures++; $display("FAIL reject_pulse: got %b expected 1", bus_a.reject_out); end
        checks++; if (bus_a.playing_note_out !== 5'd0) begin failures++; $display("FAIL reject_note_kept: got %0d expected 0", bus_a.playing_note_out); end
        checks++; if (bus_a.busy_out !== 1'b1) begin failures++; $display("FAIL reject_busy: got %b expected 1", bus_a.busy_out); end
        idle_cycle();
        checks++; if (bus_a.reject_out !== 1'b0) begin failures++; $display("FAIL reject_single: got %b expected 0", bus_a.reject_out); end
        for (int k = 3; k < 8; k++) begin
            tick();
            checks++; if (bus_a.audio_out !== exp_s[k]) begin failures++; $display("FAIL reject_post_sample[%0d]: got %02h expected %02h", k + 1, bus_a.audio_out, exp_s[k]); end
        end
        checks++; if (bus_a.busy_out !== 1'b0) begin failures++; $display("FAIL reject_end_busy: got %b expected 0", bus_a.busy_out); end
    endtask

    task automatic test_retrigger_silence();
        logic [7:0] exp_s [8] = '{8'h0A, 8'h15, 8'h1F, 8'h2A, 8'h34, 8'h3F, 8'h49, 8'h54};
        send_note(6'h20);
        idle_cycle();
        tick();
        tick();
        checks++; if (bus_a.audio_out !== 8'h0F) begin failures++; $display("FAIL retrig_pre_sample: got %02h expected 0F", bus_a.audio_out); end
        send_note(6'h25);
        checks++; if (bus_a.playing_note_out !== 5'd5) begin failures++; $display("FAIL retrig_note: got %0d expected 5", bus_a.playing_note_out); end
        idle_cycle();
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++; if (bus_a.audio_out !== exp_s[k]) begin failures++; $display("FAIL retrig_sample[%0d]: got %02h expected %02h", k + 1, bus_a.audio_out, exp_s[k]); end
        end
        checks++; if (bus_a.busy_out !== 1'b0) begin failures++; $display("FAIL retrig_end_busy: got %b expected 0", bus_a.busy_out); end
        tick();
        checks++; if (bus_a.audio_out !== 8'h80) begin failures++; $display("FAIL retrig_after_end: got %02h expected 80", bus_a.audio_out); end

        send_note(6'h20);
        idle_cycle();
        tick();
        checks++; if (bus_a.audio_out !== 8'h07) begin failures++; $display("FAIL silence_pre_sample: got %02h expected 07", bus_a.audio_out); end
        send_note(6'h00);
        checks++; if (bus_a.busy_out !== 1'b0) begin failures++; $display("FAIL silence_busy: got %b expected 0", bus_a.busy_out); end
        tick();
        checks++; if (bus_a.audio_out !== 8'h80) begin failures++; $display("FAIL silence_sample: got %02h expected 80", bus_a.audio_out); end
    endtask

    task automatic test_coincident_and_reset();
        send_note(6'h20);
        idle_cycle();
        tick();
        tick();
        tick();
        checks++; if (bus_a.audio_out !== 8'h17) begin failures++; $display("FAIL coinc_pre_sample: got %02h expected 17", bus_a.audio_out); end
        // Command and tick in the same cycle: the tick uses the old note.
        bus_a.sample_tick_in = 1'b1;
        bus_a.note_valid_in  = 1'b1;
        bus_a.note_index_in  = 6'h25;
        @(negedge clk);
        bus_a.sample_tick_in = 1'b0;
        bus_a.note_valid_in  = 1'b0;
        bus_a.note_index_in  = 6'h00;
        $display("coincident tick+cmd: audio=%02h valid=%b note=%0d", bus_a.audio_out, bus_a.audio_valid_out, bus_a.playing_note_out);
        checks++; if (bus_a.audio_out !== 8'h1F) begin failures++; $display("FAIL coinc_old_sample: got %02h expected 1F", bus_a.audio_out); end
        checks++; if (bus_a.audio_valid_out !== 1'b1) begin failures++; $display("FAIL coinc_valid: got %b expected 1", bus_a.audio_valid_out); end
        checks++; if (bus_a.playing_note_out !== 5'd5) begin failures++; $display("FAIL coinc_note: got %0d expected 5", bus_a.playing_note_out); end
        idle_cycle();
        tick();
        checks++; if (bus_a.audio_out !== 8'h0A) begin failures++; $display("FAIL coinc_new_sample: got %02h expected 0A", bus_a.audio_out); end
        // Reset mid-play, with a tick pending in the same cycle.
        bus_a.sample_tick_in = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        bus_a.sample_tick_in = 1'b0;
        $display("reset mid-play: audio=%02h valid=%b busy=%b", bus_a.audio_out, bus_a.audio_valid_out, bus_a.busy_out);
        checks++; if (bus_a.audio_out !== 8'h80) begin failures++; $display("FAIL rst_mid_audio: got %02h expected 80", bus_a.audio_out); end
        checks++; if (bus_a.audio_valid_out !== 1'b0) begin failures++; $display("FAIL rst_mid_valid: got %b expected 0", bus_a.audio_valid_out); end
        checks++; if (bus_a.busy_out !== 1'b0) begin failures++; $display("FAIL rst_mid_busy: got %b expected 0", bus_a.busy_out); end
        checks++; if (bus_a.playing_note_out !== 5'd0) begin failures++; $display("FAIL rst_mid_note: got %0d expected 0", bus_a.playing_note_out); end
        rst = 1'b0;
        tick();
        checks++; if (bus_a.audio_out !== 8'h80) begin failures++; $display("FAIL rst_post_audio: got %02h expected 80", bus_a.audio_out); end
        checks++; if (bus_a.busy_out !== 1'b0) begin failures++; $display("FAIL rst_post_busy: got %b expected 0", bus_a.busy_out); end
    endtask

    initial begin
        rst                  = 1'b1;
        bus_a.note_valid_in  = 1'b0;
        bus_a.note_index_in  = 6'h00;
        bus_a.sample_tick_in = 1'b0;
        @(negedge clk);
        test_reset();
        test_idle_ticks();
        test_note0_play();
        test_note21_wrap();
        test_reject();
        test_retrigger_silence();
        test_coincident_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/note_tone_synth.md
Name: note_tone_synth

Overview:
- Inverse of the bin-to-note lookup: takes a transcribed note index and plays it back as an audible tone.
- Sits after the note lookup stage and feeds the audio output path (PWM/DAC), so users can hear what was transcribed.
- Maps the note index to a phase increment through a fixed 22-entry bin table.
- Runs a phase accumulator at the audio sample rate and emits an unsigned sawtooth for a fixed number of samples per note.

Parameters:
- NUM_NOTES, 22, number of valid notes (indices 0..NUM_NOTES-1).
- PHASE_W, 24, phase accumulator width.
- SAMPLE_W, 8, output sample width.
- INC_PER_BIN, 4096, phase increment per table bin unit.
- DURATION_TICKS, 4800, samples played per accepted note.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- note_valid_in  input  1  one-cycle strobe: note_index_in is a command
- note_index_in  input  6  bit5 = note present, bits[4:0] = note number; matches note lookup output format
- sample_tick_in  input  1  one-cycle audio sample-rate strobe
- audio_out  output  SAMPLE_W  unsigned sample, midscale = 2^(SAMPLE_W-1)
- audio_valid_out  output  1  pulses once per accepted sample tick
- busy_out  output  1  high when state != IDLE
- playing_note_out  output  5  note number currently loaded
- reject_out  output  1  one-cycle pulse on an out-of-range note command

Behaviour:
- Clock and reset: one clock, clk_in. Reset is synchronous and active-high on rst_in.
- Reset values:
  - State IDLE.
  - phase = 0, inc = 0, tick_count = 0.
  - audio_out = 128 (midscale).
  - audio_valid_out, busy_out, reject_out = 0.
  - playing_note_out = 0.
  - rst_in mid-play aborts immediately, with no further samples from the old note.
- Bin table (entries 0..21): 126,133,141,149,158,168,178,188,200,212,224,238,252,267,283,299,317,336,356,377,400,424.
  - inc = table[n] * INC_PER_BIN, truncated to PHASE_W bits.
- States: IDLE, LOAD, PLAY.
- Note command acceptance (note_valid_in=1, in any state):
  - If bit5=1 and bits[4:0] < NUM_NOTES:
    - Next state LOAD.
    - Latch playing_note_out.
    - This retriggers any note already playing.
  - If bit5=1 and bits[4:0] >= NUM_NOTES:
    - reject_out=1 on the next cycle.
    - State and playback are unchanged.
  - If bit5=0 (silence):
    - Next state IDLE.
    - phase cleared.
    - audio_out is midscale from the next tick.
- LOAD (exactly 1 cycle):
  - inc <= table lookup.
  - phase <= 0.
  - tick_count <= 0.
  - Next state PLAY.
  - A sample_tick_in in LOAD emits midscale.
- PLAY, on sample_tick_in:
  - phase <= phase + inc (mod 2^PHASE_W).
  - audio_out <= top SAMPLE_W bits of (phase + inc).
  - tick_count increments.
  - When the DURATION_TICKS-th sample is emitted, next state IDLE.
  - So exactly DURATION_TICKS non-midscale-path samples are emitted.
- IDLE, on sample_tick_in: audio_out <= midscale.
- audio_valid_out:
  - Registered; goes high the cycle after every sample_tick_in, in all states.
  - Gives a constant-rate stream.
  - audio_out updates in the same cycle audio_valid_out rises.
- Note command and sample_tick_in in the same cycle:
  - The tick is processed with the current state and emits a sample.
  - The command then takes effect, overriding the phase/state update.
- Latency: a note accepted at cycle t gives LOAD at t+1 and PLAY at t+2. The first tick at or after t+2 produces the first tone sample one cycle later.
- busy_out reflects the registered state.

Test Plan:
1. Reset, then 3 ticks with no note -> audio_valid_out pulses 3 times, audio_out=128 each, busy_out=0.
2. Note 0x20 (note 0, inc=516096=0x07E000), then ticks -> samples 0x07, 0x0F, 0x17, …; busy_out=1; after DURATION_TICKS samples (set DURATION_TICKS=8 in the bench) state returns to IDLE and audio_out=128.
3. Note 0x35 (note 21, inc=424*4096=0x1A8000) -> first samples 0x1A, 0x35, 0x4F, …; phase wraps past 2^24 without glitch (sample 10 = 0x09).
4. Note 0x37 (23, out of range) while note 0 is playing -> reject_out pulses once; note 0 samples continue uninterrupted.
5. Note 0x25 during PLAY of note 0 -> retrigger: phase resets, playing_note_out=5, tick_count restarts, full duration is replayed. A silence command 0x00 -> IDLE, next sample 128.
6. Note command coincident with sample_tick_in, and rst_in asserted mid-PLAY -> the coincident tick emits an old-state sample. Reset forces audio_out=128 and busy_out=0 on the next cycle with no late samples.
